// File: rtl/bp_event_counter_bank_pkg.sv
// Shared types and constants for the event counter bank.
package bp_event_counter_bank_pkg;

    // Readout FSM states
    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_resp = 1'b1
    } bp_evc_state_e;

    // Counter overflow modes (values of saturate_p)
    localparam int e_evc_wrap = 0;
    localparam int e_evc_sat  = 1;

    // Address width that stays >= 1 even for a single-channel bank
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_event_counter_bank_slice.sv
// One event channel: live counter with sticky overflow, plus shadow copy.
module bp_event_counter_slice
    import bp_event_counter_bank_pkg::*;
#(
    parameter int width_p    = 32,
    parameter int saturate_p = e_evc_wrap
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,      // clear or freeze, highest priority
    input  logic               inc_i,        // already qualified by the global enable
    input  logic               snapshot_i,
    output logic [width_p-1:0] shadow_cnt_o,
    output logic               shadow_ovf_o
);

    logic [width_p-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [width_p-1:0] shadow_q, shadow_d;
    logic               shadow_ovf_q, shadow_ovf_d;
    logic               at_max;

    assign at_max = &cnt_q;

    // Live counter next state: clear beats increment; max either wraps or sticks
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (at_max) begin
                ovf_d = 1'b1;
                cnt_d = (saturate_p == e_evc_sat) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + width_p'(1);
            end
        end
    end

    // Shadow captures the pre-update live value, so a same-cycle increment or clear is not seen
    always_comb begin
        shadow_d     = shadow_q;
        shadow_ovf_d = shadow_ovf_q;
        if (snapshot_i) begin
            shadow_d     = cnt_q;
            shadow_ovf_d = ovf_q;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            shadow_q     <= '0;
            shadow_ovf_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            shadow_q     <= shadow_d;
            shadow_ovf_q <= shadow_ovf_d;
        end
    end

    assign shadow_cnt_o = shadow_q;
    assign shadow_ovf_o = shadow_ovf_q;

endmodule

// File: rtl/bp_event_counter_bank.sv
// Bank of per-event performance counters with atomic snapshot and a
// valid/ready readout port over the shadow registers.
module bp_event_counter_bank
    import bp_event_counter_bank_pkg::*;
#(
    parameter int num_events_p  = 22,
    parameter int width_p       = 32,
    parameter int saturate_p    = e_evc_wrap,
    parameter int addr_width_lp = safe_clog2(num_events_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     freeze_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [num_events_p-1:0]  event_i,
    input  logic                     snapshot_i,
    input  logic                     req_v_i,
    input  logic [addr_width_lp-1:0] req_addr_i,
    output logic                     req_ready_o,
    output logic                     resp_v_o,
    output logic [width_p-1:0]       resp_data_o,
    output logic                     resp_overflow_o,
    output logic                     resp_err_o,
    input  logic                     resp_yumi_i
);

    logic [num_events_p-1:0][width_p-1:0] shadow_cnt;
    logic [num_events_p-1:0]              shadow_ovf;
    logic                                 clr;

    // Freeze behaves exactly like a held clear
    assign clr = freeze_i | clear_i;

    for (genvar k = 0; k < num_events_p; k++) begin : g_ch
        bp_event_counter_slice #(
            .width_p   (width_p),
            .saturate_p(saturate_p)
        ) u_slice (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .clear_i     (clr),
            .inc_i       (enable_i & event_i[k]),
            .snapshot_i  (snapshot_i),
            .shadow_cnt_o(shadow_cnt[k]),
            .shadow_ovf_o(shadow_ovf[k])
        );
    end

    // Read mux; compare-based so an out-of-range address never indexes the array
    logic [width_p-1:0] rd_data;
    logic               rd_ovf;
    logic               addr_err;

    assign addr_err = ({1'b0, req_addr_i} >= (addr_width_lp+1)'(num_events_p));

    // Select the shadow entry matching the request address (zero if none)
    always_comb begin
        rd_data = '0;
        rd_ovf  = 1'b0;
        for (int k = 0; k < num_events_p; k++) begin
            if (req_addr_i == addr_width_lp'(k)) begin
                rd_data = shadow_cnt[k];
                rd_ovf  = shadow_ovf[k];
            end
        end
    end

    // Readout FSM and response holding registers
    bp_evc_state_e      state_q, state_d;
    logic [width_p-1:0] resp_data_q, resp_data_d;
    logic               resp_ovf_q, resp_ovf_d;
    logic               resp_err_q, resp_err_d;

    // Next-state: capture on accept in idle, hold fields until the consumer takes them
    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_ovf_d  = resp_ovf_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            e_idle: begin
                if (req_v_i) begin
                    state_d     = e_resp;
                    resp_data_d = rd_data;
                    resp_ovf_d  = rd_ovf;
                    resp_err_d  = addr_err;
                end
            end
            e_resp: begin
                if (resp_yumi_i) state_d = e_idle;
            end
            default: state_d = e_idle;
        endcase
    end

    // FSM and response registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_idle;
            resp_data_q <= '0;
            resp_ovf_q  <= 1'b0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            resp_ovf_q  <= resp_ovf_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready_o     = (state_q == e_idle);
    assign resp_v_o        = (state_q == e_resp);
    assign resp_data_o     = resp_data_q;
    assign resp_overflow_o = resp_ovf_q;
    assign resp_err_o      = resp_err_q;

endmodule

// File: tb/tb_bp_event_counter_bank.sv
// Bench for bp_event_counter_bank: a 32-bit wrap bank plus two 4-bit banks
// (wrap and saturate) sharing the event stimulus, each with its own read port.
module tb_bp_event_counter_bank;

    localparam int NE = 22;

    logic          clk_i = 1'b0;
    logic          reset_n = 1'b0;
    logic          freeze = 1'b0, enable = 1'b1, clear = 1'b0, snapshot = 1'b0;
    logic [NE-1:0] event_v = '0;
    logic [4:0]    req_addr = '0;
    logic [2:0]    req_v = '0, yumi = '0;
    logic [2:0]    ready, resp_v, ovf, err;
    logic [31:0]   d0;
    logic [3:0]    d1, d2;
    logic [31:0]   rdata [3];

    assign rdata[0] = d0;
    assign rdata[1] = {28'b0, d1};
    assign rdata[2] = {28'b0, d2};

    always #5 clk_i = ~clk_i;

    bp_event_counter_bank #(.num_events_p(NE), .width_p(32), .saturate_p(0)) u_dut (
        .clk_i(clk_i), .reset_n_i(reset_n), .freeze_i(freeze), .enable_i(enable),
        .clear_i(clear), .event_i(event_v), .snapshot_i(snapshot), .req_v_i(req_v[0]),
        .req_addr_i(req_addr), .req_ready_o(ready[0]), .resp_v_o(resp_v[0]),
        .resp_data_o(d0), .resp_overflow_o(ovf[0]), .resp_err_o(err[0]),
        .resp_yumi_i(yumi[0]));

    bp_event_counter_bank #(.num_events_p(NE), .width_p(4), .saturate_p(0)) u_dut_w (
        .clk_i(clk_i), .reset_n_i(reset_n), .freeze_i(freeze), .enable_i(enable),
        .clear_i(clear), .event_i(event_v), .snapshot_i(snapshot), .req_v_i(req_v[1]),
        .req_addr_i(req_addr), .req_ready_o(ready[1]), .resp_v_o(resp_v[1]),
        .resp_data_o(d1), .resp_overflow_o(ovf[1]), .resp_err_o(err[1]),
        .resp_yumi_i(yumi[1]));

    bp_event_counter_bank #(.num_events_p(NE), .width_p(4), .saturate_p(1)) u_dut_s (
        .clk_i(clk_i), .reset_n_i(reset_n), .freeze_i(freeze), .enable_i(enable),
        .clear_i(clear), .event_i(event_v), .snapshot_i(snapshot), .req_v_i(req_v[2]),
        .req_addr_i(req_addr), .req_ready_o(ready[2]), .resp_v_o(resp_v[2]),
        .resp_data_o(d2), .resp_overflow_o(ovf[2]), .resp_err_o(err[2]),
        .resp_yumi_i(yumi[2]));

    typedef struct {
        int          sel;
        logic [31:0] data;
        logic        ovf;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Responses are scored when the handshake completes
    exp_t e;
    always @(negedge clk_i) begin
        for (int s = 0; s < 3; s++) begin
            if (reset_n && resp_v[s] && yumi[s]) begin
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("resp_sel", 64'(s), 64'(e.sel));
                    chk("resp_data", 64'(rdata[s]), 64'(e.data));
                    chk("resp_ovf", 64'(ovf[s]), 64'(e.ovf));
                    chk("resp_err", 64'(err[s]), 64'(e.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            event_v = NE'(1) << ch;
            tick();
        end
        event_v = '0;
    endtask

    task automatic snap();
        snapshot = 1'b1;
        tick();
        snapshot = 1'b0;
    endtask

    task automatic rd(input int sel, input int addr, input logic [31:0] d, input logic o, input logic er);
        int n;
        sb_q.push_back('{sel, d, o, er});
        req_addr   = 5'(addr);
        req_v[sel] = 1'b1;
        n = 0;
        while (!ready[sel] && n < 20) begin
            tick();
            n++;
        end
        chk("rd_wait", 64'(ready[sel]), 64'd1);
        tick();
        req_v[sel] = 1'b0;
        chk("rd_latency", 64'(resp_v[sel]), 64'd1);
        yumi[sel] = 1'b1;
        tick();
        yumi[sel] = 1'b0;
        chk("rd_done", 64'(resp_v[sel]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_ready", 64'(ready[0]), 64'd1);
        chk("rst_resp_v", 64'(resp_v[0]), 64'd0);
        chk("rst_data", 64'(d0), 64'd0);
        chk("rst_ovf", 64'(ovf[0]), 64'd0);
        chk("rst_err", 64'(err[0]), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Basic count, and enable gating
        strobe(3, 5);
        enable = 1'b0;
        strobe(5, 3);
        enable = 1'b1;
        snap();
        rd(0, 3, 5, 0, 0);
        rd(0, 5, 0, 0, 0);

        // 17 strobes on ch0: 4-bit wrap -> 1, 4-bit saturate -> 15, both overflow
        strobe(0, 17);
        snap();
        rd(1, 0, 1, 1, 0);
        rd(2, 0, 15, 1, 0);
        rd(0, 0, 17, 0, 0);

        // Snapshot does not see a same-cycle increment
        strobe(1, 7);
        event_v  = NE'(1) << 1;
        snapshot = 1'b1;
        tick();
        event_v  = '0;
        snapshot = 1'b0;
        strobe(1, 2);
        rd(0, 1, 7, 0, 0);
        snap();
        rd(0, 1, 10, 0, 0);

        // Out-of-range read held for 5 cycles with a pending request behind it
        sb_q.push_back('{0, 32'd0, 1'b0, 1'b1});
        sb_q.push_back('{0, 32'd10, 1'b0, 1'b0});
        req_addr = 5'(NE);
        req_v[0] = 1'b1;
        tick();
        req_addr = 5'd1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_v", 64'(resp_v[0]), 64'd1);
            chk("hold_ready", 64'(ready[0]), 64'd0);
            chk("hold_err", 64'(err[0]), 64'd1);
            chk("hold_data", 64'(d0), 64'd0);
            tick();
        end
        yumi[0] = 1'b1;
        tick();
        yumi[0] = 1'b0;
        chk("post_yumi_v", 64'(resp_v[0]), 64'd0);
        chk("post_yumi_ready", 64'(ready[0]), 64'd1);
        tick();
        req_v[0] = 1'b0;
        chk("pend_latency", 64'(resp_v[0]), 64'd1);
        yumi[0] = 1'b1;
        tick();
        yumi[0] = 1'b0;

        // Freeze with events holds counts and overflow at 0
        strobe(2, 4);
        freeze  = 1'b1;
        event_v = (NE'(1) << 2) | NE'(1);
        tick(); tick(); tick();
        freeze  = 1'b0;
        event_v = '0;
        snap();
        rd(0, 2, 0, 0, 0);
        rd(1, 0, 0, 0, 0);

        // Clear beats a same-cycle increment
        strobe(2, 4);
        event_v = NE'(1) << 2;
        clear   = 1'b1;
        tick();
        event_v = '0;
        clear   = 1'b0;
        snap();
        rd(0, 2, 0, 0, 0);

        // Snapshot together with clear captures pre-clear values
        strobe(4, 3);
        clear    = 1'b1;
        snapshot = 1'b1;
        tick();
        clear    = 1'b0;
        snapshot = 1'b0;
        rd(0, 4, 3, 0, 0);
        snap();
        rd(0, 4, 0, 0, 0);

        // Reset while a response is pending
        strobe(0, 3);
        strobe(1, 3);
        snap();
        req_addr = 5'd1;
        req_v[0] = 1'b1;
        tick();
        req_v[0] = 1'b0;
        chk("pre_rst_v", 64'(resp_v[0]), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_v", 64'(resp_v[0]), 64'd0);
        chk("async_rst_ready", 64'(ready[0]), 64'd1);
        chk("async_rst_data", 64'(d0), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        rd(0, 1, 0, 0, 0);
        rd(1, 0, 0, 0, 0);
        rd(2, 0, 0, 0, 0);

        tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
